// File: rtl/hpi_responder.sv
// Host port interface responder: a 16-bit host register window onto a
// word memory, plus a pair of single-entry mailboxes between host and device.
module hpi_responder #(
  parameter int MEM_WORDS = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [1:0]  hpi_addr,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic [15:0] dev_mbx_data,
  output logic        dev_mbx_valid,
  input  logic        dev_mbx_ack,
  input  logic        dev_mbx_wr,
  input  logic [15:0] dev_mbx_wdata,
  output logic        hpi_int
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [1:0] REG_DATA = 2'b00;
  localparam logic [1:0] REG_MBX  = 2'b01;
  localparam logic [1:0] REG_ADDR = 2'b10;
  localparam logic [1:0] REG_STAT = 2'b11;

  logic [15:0] mem [MEM_WORDS];

  logic        rd_act, wr_act, rd_start, wr_start;
  logic        rd_act_q, wr_act_q;
  // Blocks strobes that were already active when reset released.
  logic        blk_q, blk_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] h2d_q, h2d_d;
  logic        h2d_full_q, h2d_full_d;
  logic [15:0] d2h_q, d2h_d;
  logic        d2h_full_q, d2h_full_d;
  logic        ovr_q, ovr_d;
  logic [15:0] dout_q, dout_d;
  logic        oe_q, oe_d;
  logic [AW-1:0] idx;
  logic [15:0] mem_rd;

  assign rd_act   = !hpi_cs_n && !hpi_r_n && hpi_w_n;
  assign wr_act   = !hpi_cs_n && !hpi_w_n && hpi_r_n;
  assign rd_start = rd_act && !rd_act_q && !blk_q;
  assign wr_start = wr_act && !wr_act_q && !blk_q;

  // Byte pointer: bit 0 and bits above the memory depth are ignored.
  assign idx    = ptr_q[AW:1];
  assign mem_rd = mem[idx];

  assign hpi_data_out  = dout_q;
  assign hpi_data_oe   = oe_q;
  assign dev_mbx_data  = h2d_q;
  assign dev_mbx_valid = h2d_full_q;
  assign hpi_int       = d2h_full_q;

  // Next-state for pointer, mailboxes, status and read return path.
  always_comb begin
    ptr_d      = ptr_q;
    h2d_d      = h2d_q;
    h2d_full_d = h2d_full_q;
    d2h_d      = d2h_q;
    d2h_full_d = d2h_full_q;
    ovr_d      = ovr_q;
    dout_d     = dout_q;
    oe_d       = rd_start || (oe_q && rd_act);
    blk_d      = blk_q && (rd_act || wr_act);

    // Device side first so that host accesses in the same cycle override.
    if (dev_mbx_ack) h2d_full_d = 1'b0;
    if (dev_mbx_wr) begin
      d2h_d      = dev_mbx_wdata;
      d2h_full_d = 1'b1;
    end

    if (wr_start) begin
      case (hpi_addr)
        REG_DATA: ptr_d = ptr_q + 16'd2;
        REG_MBX: begin
          h2d_d      = hpi_data_in;
          h2d_full_d = 1'b1;
          // An ack in the same cycle means the old word was consumed.
          if (h2d_full_q && !dev_mbx_ack) ovr_d = 1'b1;
        end
        REG_ADDR: ptr_d = hpi_data_in;
        default: ;
      endcase
    end

    if (rd_start) begin
      case (hpi_addr)
        REG_DATA: begin
          dout_d = mem_rd;
          ptr_d  = ptr_q + 16'd2;
        end
        REG_MBX: begin
          dout_d = d2h_q;
          if (!dev_mbx_wr) d2h_full_d = 1'b0;
        end
        REG_ADDR: dout_d = ptr_q;
        default: begin
          dout_d = {13'b0, ovr_q, d2h_full_q, h2d_full_q};
          ovr_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers; reset overrides any access or device pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_act_q   <= 1'b0;
      wr_act_q   <= 1'b0;
      blk_q      <= 1'b1;
      ptr_q      <= '0;
      h2d_q      <= '0;
      h2d_full_q <= 1'b0;
      d2h_q      <= '0;
      d2h_full_q <= 1'b0;
      ovr_q      <= 1'b0;
      dout_q     <= '0;
      oe_q       <= 1'b0;
    end else begin
      rd_act_q   <= rd_act;
      wr_act_q   <= wr_act;
      blk_q      <= blk_d;
      ptr_q      <= ptr_d;
      h2d_q      <= h2d_d;
      h2d_full_q <= h2d_full_d;
      d2h_q      <= d2h_d;
      d2h_full_q <= d2h_full_d;
      ovr_q      <= ovr_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
    end
  end

  // Word memory write port; contents survive reset.
  always_ff @(posedge Clk) begin
    if (!Reset && wr_start && hpi_addr == REG_DATA) mem[idx] <= hpi_data_in;
  end

endmodule

// File: tb/tb_hpi_responder.sv
// Self-checking bench for hpi_responder: host reads go through a scoreboard
// queue, popped when the read-enable output rises.
module tb_hpi_responder;

  localparam logic [1:0] A_DATA = 2'b00;
  localparam logic [1:0] A_MBX  = 2'b01;
  localparam logic [1:0] A_ADDR = 2'b10;
  localparam logic [1:0] A_STAT = 2'b11;

  logic        Clk;
  logic        Reset;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n;
  logic [1:0]  hpi_addr;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] dev_mbx_data;
  logic        dev_mbx_valid;
  logic        dev_mbx_ack;
  logic        dev_mbx_wr;
  logic [15:0] dev_mbx_wdata;
  logic        hpi_int;

  int n_checks = 0;
  int n_errs   = 0;
  int oe_cnt   = 0;
  logic [15:0] exp_q[$];

  hpi_responder #(.MEM_WORDS(256)) dut (
    .Clk(Clk), .Reset(Reset),
    .hpi_cs_n(hpi_cs_n), .hpi_r_n(hpi_r_n), .hpi_w_n(hpi_w_n),
    .hpi_addr(hpi_addr), .hpi_data_in(hpi_data_in),
    .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
    .dev_mbx_data(dev_mbx_data), .dev_mbx_valid(dev_mbx_valid),
    .dev_mbx_ack(dev_mbx_ack), .dev_mbx_wr(dev_mbx_wr),
    .dev_mbx_wdata(dev_mbx_wdata), .hpi_int(hpi_int)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic hwrite(input logic [1:0] a, input logic [15:0] d);
    hpi_addr = a; hpi_data_in = d; hpi_cs_n = 1'b0; hpi_w_n = 1'b0;
    cyc(1);
    hpi_cs_n = 1'b1; hpi_w_n = 1'b1;
    cyc(1);
  endtask

  task automatic hread(input logic [1:0] a, input logic [15:0] exp, input int hold);
    exp_q.push_back(exp);
    hpi_addr = a; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    cyc(hold);
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
    cyc(1);
  endtask

  // Scoreboard monitor: one pop per rising edge of the read-enable output.
  initial begin
    logic oe_prev;
    logic [15:0] e;
    oe_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (hpi_data_oe === 1'b1) oe_cnt++;
      if (hpi_data_oe === 1'b1 && !oe_prev) begin
        if (exp_q.size() == 0) check("unexp_read", 32'(hpi_data_out), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          check("rd_data", 32'(hpi_data_out), 32'(e));
        end
      end
      oe_prev = (hpi_data_oe === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
    hpi_addr = 2'b00; hpi_data_in = 16'h0;
    dev_mbx_ack = 1'b0; dev_mbx_wr = 1'b0; dev_mbx_wdata = 16'h0;
    Reset = 1'b1;
    cyc(3);
    check("rst_dout",  32'(hpi_data_out), 32'h0);
    check("rst_oe",    32'(hpi_data_oe), 32'h0);
    check("rst_valid", 32'(dev_mbx_valid), 32'h0);
    check("rst_mdata", 32'(dev_mbx_data), 32'h0);
    check("rst_int",   32'(hpi_int), 32'h0);
    Reset = 1'b0;
    cyc(1);

    // Sequential data access with auto-increment
    hwrite(A_ADDR, 16'h0010);
    hwrite(A_DATA, 16'h1234);
    hwrite(A_DATA, 16'hABCD);
    hwrite(A_ADDR, 16'h0010);
    hread(A_DATA, 16'h1234, 1);
    hread(A_DATA, 16'hABCD, 1);
    hread(A_ADDR, 16'h0014, 1);

    // Pointer wrap and address aliasing
    hwrite(A_ADDR, 16'hFFFE);
    hwrite(A_DATA, 16'h5555);
    hread(A_ADDR, 16'h0000, 1);
    hwrite(A_ADDR, 16'h01FE);
    hread(A_DATA, 16'h5555, 1);

    // Host-to-device mailbox and overrun
    hwrite(A_MBX, 16'h00A5);
    check("mbx_valid", 32'(dev_mbx_valid), 32'h1);
    check("mbx_data",  32'(dev_mbx_data), 32'h00A5);
    hwrite(A_MBX, 16'h00A6);
    check("mbx_data2", 32'(dev_mbx_data), 32'h00A6);
    hread(A_STAT, 16'h0005, 1);
    hread(A_STAT, 16'h0001, 1);
    dev_mbx_ack = 1'b1; cyc(1); dev_mbx_ack = 1'b0;
    check("ack_valid", 32'(dev_mbx_valid), 32'h0);
    dev_mbx_ack = 1'b1; cyc(1); dev_mbx_ack = 1'b0;
    check("ack_idle_valid", 32'(dev_mbx_valid), 32'h0);
    check("ack_idle_data",  32'(dev_mbx_data), 32'h00A6);

    // Device-to-host mailbox
    dev_mbx_wdata = 16'hBEEF; dev_mbx_wr = 1'b1; cyc(1); dev_mbx_wr = 1'b0;
    check("int_set", 32'(hpi_int), 32'h1);
    hread(A_MBX, 16'hBEEF, 1);
    check("int_clr", 32'(hpi_int), 32'h0);
    dev_mbx_wdata = 16'h1357; dev_mbx_wr = 1'b1; cyc(1); dev_mbx_wr = 1'b0;
    exp_q.push_back(16'h1357);
    hpi_addr = A_MBX; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    dev_mbx_wdata = 16'hCAFE; dev_mbx_wr = 1'b1;
    cyc(1);
    dev_mbx_wr = 1'b0; hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
    cyc(1);
    check("int_hold", 32'(hpi_int), 32'h1);
    hread(A_MBX, 16'hCAFE, 1);
    check("int_clr2", 32'(hpi_int), 32'h0);

    // Long strobe: one access, enable high for exactly five cycles
    hwrite(A_ADDR, 16'h0020);
    hwrite(A_DATA, 16'h7777);
    hwrite(A_ADDR, 16'h0020);
    base = oe_cnt;
    hread(A_DATA, 16'h7777, 5);
    check("oe_cycles", 32'(oe_cnt - base), 32'd5);
    hread(A_ADDR, 16'h0022, 1);

    // Read and write strobes together: no access
    hpi_addr = A_ADDR; hpi_data_in = 16'hDEAD;
    hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
    cyc(1);
    check("both_oe1", 32'(hpi_data_oe), 32'h0);
    cyc(1);
    check("both_oe2", 32'(hpi_data_oe), 32'h0);
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1; hpi_w_n = 1'b1;
    cyc(1);
    hread(A_ADDR, 16'h0022, 1);
    hread(A_STAT, 16'h0000, 1);

    // Reset in the middle of a read strobe, strobe held past release
    hwrite(A_MBX, 16'h0042);
    dev_mbx_wdata = 16'h4444; dev_mbx_wr = 1'b1; cyc(1); dev_mbx_wr = 1'b0;
    check("pre_rst_valid", 32'(dev_mbx_valid), 32'h1);
    check("pre_rst_int",   32'(hpi_int), 32'h1);
    exp_q.push_back(16'h0022);
    hpi_addr = A_ADDR; hpi_cs_n = 1'b0; hpi_r_n = 1'b0;
    cyc(2);
    Reset = 1'b1;
    cyc(1);
    check("mrst_dout",  32'(hpi_data_out), 32'h0);
    check("mrst_oe",    32'(hpi_data_oe), 32'h0);
    check("mrst_valid", 32'(dev_mbx_valid), 32'h0);
    check("mrst_mdata", 32'(dev_mbx_data), 32'h0);
    check("mrst_int",   32'(hpi_int), 32'h0);
    hpi_addr = A_DATA;
    cyc(1);
    Reset = 1'b0;
    cyc(3);
    check("held_oe", 32'(hpi_data_oe), 32'h0);
    hpi_cs_n = 1'b1; hpi_r_n = 1'b1;
    cyc(1);
    hread(A_ADDR, 16'h0000, 1);
    hread(A_STAT, 16'h0000, 1);

    cyc(2);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
